// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap / mret sequencer: writes mepc, mcause, mtval and mstatus through the
// CSR file's internal port one per cycle, then redirects the PC.
module csr_trap_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            TrapReq,
    input  logic [XLEN-1:0] TrapCause,
    input  logic [XLEN-1:0] TrapPC,
    input  logic [XLEN-1:0] TrapVal,
    input  logic            MretReq,
    input  logic            CSREnPipe,
    input  logic [XLEN-1:0] MstatusIn,
    input  logic [XLEN-1:0] MtvecIn,
    input  logic [XLEN-1:0] MepcIn,
    output logic            CSRGrant,
    output logic            CsrWriteEn,
    output logic [1:0]      CsrWriteSel,
    output logic [XLEN-1:0] CsrWriteData,
    output logic            Stall,
    output logic            TrapAck,
    output logic            MretAck,
    output logic            Redirect,
    output logic [XLEN-1:0] RedirectPC
);

    typedef enum logic [2:0] {
        StIdle,
        StTMepc,
        StTMcause,
        StTMtval,
        StTMstatus,
        StMMstatus,
        StRedirect
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, cause_q, val_q;
    logic            mret_q;
    logic            accept_trap, accept_mret;
    logic [XLEN-1:0] tvec_base, vec_off, trap_target;
    logic            unused_low_bits;

    assign unused_low_bits = ^{MepcIn[1:0], pc_q[1:0]};

    always_comb begin
        accept_trap = ~reset & (state_q == StIdle) & TrapReq;
        accept_mret = ~reset & (state_q == StIdle) & MretReq & ~TrapReq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cause_q <= '0;
            val_q   <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_trap) begin
                pc_q    <= TrapPC;
                cause_q <= TrapCause;
                val_q   <= TrapVal;
                mret_q  <= 1'b0;
            end else if (accept_mret) begin
                mret_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (TrapReq) begin
                    state_d = StTMepc;
                end else if (MretReq) begin
                    state_d = StMMstatus;
                end
            end
            StTMepc:    state_d = StTMcause;
            StTMcause:  state_d = StTMtval;
            StTMtval:   state_d = StTMstatus;
            StTMstatus: state_d = StRedirect;
            StMMstatus: state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Vectored mode only applies to interrupts; the offset wraps modulo 2^XLEN.
    always_comb begin
        tvec_base   = {MtvecIn[XLEN-1:2], 2'b00};
        vec_off     = {cause_q[XLEN-3:0], 2'b00};
        trap_target = tvec_base;
        if ((MtvecIn[1:0] == 2'b01) && cause_q[XLEN-1]) begin
            trap_target = tvec_base + vec_off;
        end
    end

    always_comb begin
        CSRGrant     = 1'b0;
        CsrWriteEn   = 1'b0;
        CsrWriteSel  = 2'd0;
        CsrWriteData = '0;
        Stall        = 1'b0;
        TrapAck      = 1'b0;
        MretAck      = 1'b0;
        Redirect     = 1'b0;
        RedirectPC   = '0;
        if (!reset) begin
            Stall = (state_q != StIdle) | TrapReq | MretReq;
            case (state_q)
                StIdle: begin
                    TrapAck  = TrapReq;
                    MretAck  = MretReq & ~TrapReq;
                    CSRGrant = CSREnPipe & ~TrapReq & ~MretReq;
                end
                StTMepc: begin
                    CsrWriteEn   = 1'b1;
                    CsrWriteSel  = 2'd0;
                    CsrWriteData = {pc_q[XLEN-1:2], 2'b00};
                end
                StTMcause: begin
                    CsrWriteEn   = 1'b1;
                    CsrWriteSel  = 2'd1;
                    CsrWriteData = cause_q;
                end
                StTMtval: begin
                    CsrWriteEn   = 1'b1;
                    CsrWriteSel  = 2'd2;
                    CsrWriteData = val_q;
                end
                StTMstatus: begin
                    CsrWriteEn          = 1'b1;
                    CsrWriteSel         = 2'd3;
                    CsrWriteData        = MstatusIn;
                    CsrWriteData[7]     = MstatusIn[3];
                    CsrWriteData[3]     = 1'b0;
                    CsrWriteData[12:11] = 2'b11;
                end
                StMMstatus: begin
                    CsrWriteEn          = 1'b1;
                    CsrWriteSel         = 2'd3;
                    CsrWriteData        = MstatusIn;
                    CsrWriteData[3]     = MstatusIn[7];
                    CsrWriteData[7]     = 1'b1;
                    CsrWriteData[12:11] = 2'b11;
                end
                StRedirect: begin
                    Redirect   = 1'b1;
                    RedirectPC = mret_q ? {MepcIn[XLEN-1:2], 2'b00} : trap_target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_csr_trap_sequencer;

    typedef struct packed {
        logic        rst, treq, mreq, csren;
        logic [31:0] cause, pc, val, ms, mtvec, mepc;
    } ins_t;

    typedef struct packed {
        logic        grant, we;
        logic [1:0]  sel;
        logic [31:0] data;
        logic        stall, tack, mack, redir;
        logic [31:0] rpc;
    } outs_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        TrapReq = 1'b0, MretReq = 1'b0, CSREnPipe = 1'b0;
    logic [31:0] TrapCause = '0, TrapPC = '0, TrapVal = '0;
    logic [31:0] MstatusIn = '0, MtvecIn = '0, MepcIn = '0;
    logic        CSRGrant, CsrWriteEn, Stall, TrapAck, MretAck, Redirect;
    logic [1:0]  CsrWriteSel;
    logic [31:0] CsrWriteData, RedirectPC;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .TrapReq      (TrapReq),
        .TrapCause    (TrapCause),
        .TrapPC       (TrapPC),
        .TrapVal      (TrapVal),
        .MretReq      (MretReq),
        .CSREnPipe    (CSREnPipe),
        .MstatusIn    (MstatusIn),
        .MtvecIn      (MtvecIn),
        .MepcIn       (MepcIn),
        .CSRGrant     (CSRGrant),
        .CsrWriteEn   (CsrWriteEn),
        .CsrWriteSel  (CsrWriteSel),
        .CsrWriteData (CsrWriteData),
        .Stall        (Stall),
        .TrapAck      (TrapAck),
        .MretAck      (MretAck),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC)
    );

    // c = {rst, treq, mreq, csren}
    function automatic ins_t mk_in(input logic [3:0] c, input logic [31:0] cause, pc, val, ms,
                                   mtvec, mepc);
        ins_t r;
        {r.rst, r.treq, r.mreq, r.csren} = c;
        r.cause = cause; r.pc = pc; r.val = val;
        r.ms = ms; r.mtvec = mtvec; r.mepc = mepc;
        return r;
    endfunction

    // f = {grant, we, stall, tack, mack, redir}
    function automatic outs_t mk_out(input logic [5:0] f, input logic [1:0] sel,
                                     input logic [31:0] data, rpc);
        outs_t r;
        {r.grant, r.we, r.stall, r.tack, r.mack, r.redir} = f;
        r.sel = sel; r.data = data; r.rpc = rpc;
        return r;
    endfunction

    function automatic outs_t actual();
        outs_t r;
        r.grant = CSRGrant; r.we = CsrWriteEn; r.sel = CsrWriteSel; r.data = CsrWriteData;
        r.stall = Stall; r.tack = TrapAck; r.mack = MretAck; r.redir = Redirect;
        r.rpc = RedirectPC;
        return r;
    endfunction

    task automatic drive(input ins_t in);
        @(negedge clk);
        reset = in.rst; TrapReq = in.treq; MretReq = in.mreq; CSREnPipe = in.csren;
        TrapCause = in.cause; TrapPC = in.pc; TrapVal = in.val;
        MstatusIn = in.ms; MtvecIn = in.mtvec; MepcIn = in.mepc;
        #1;
    endtask

    task automatic check_out(input string name, input outs_t exp);
        outs_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
    endfunction

    vec_t        tv[$];
    ins_t        cur;
    int          q[$];
    logic [31:0] m_pc, m_cause, m_val;
    bit          tpend, mpend;

    initial begin
        // Reset with requests present, then idle
        tv.push_back({mk_in(4'b1111, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b000000, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b000000, 2'd0, 32'h0, 32'h0)});
        // Direct-mode trap
        tv.push_back({mk_in(4'b0100, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b001100, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b011000, 2'd0, 32'h204, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b011000, 2'd1, 32'h2, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b011000, 2'd2, 32'hDEADBEEF, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b011000, 2'd3, 32'h1880, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b001001, 2'd0, 32'h0, 32'h1000)});
        tv.push_back({mk_in(4'b0000, 32'h2, 32'h204, 32'hDEADBEEF, 32'h8, 32'h1000, 32'h0),
                      mk_out(6'b000000, 2'd0, 32'h0, 32'h0)});
        // mret
        tv.push_back({mk_in(4'b0010, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h1000, 32'h208),
                      mk_out(6'b001010, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h1000, 32'h208),
                      mk_out(6'b011000, 2'd3, 32'h1888, 32'h0)});
        tv.push_back({mk_in(4'b0000, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h1000, 32'h208),
                      mk_out(6'b001001, 2'd0, 32'h0, 32'h208)});
        tv.push_back({mk_in(4'b0000, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h1000, 32'h208),
                      mk_out(6'b000000, 2'd0, 32'h0, 32'h0)});
        // Arbitration: grant when idle, none once a trap is requested or running
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b100000, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0101, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b001100, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b011000, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b011000, 2'd1, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b011000, 2'd2, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b011000, 2'd3, 32'h1800, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b001001, 2'd0, 32'h0, 32'h0)});
        tv.push_back({mk_in(4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0),
                      mk_out(6'b100000, 2'd0, 32'h0, 32'h0)});

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].in);
            check_out($sformatf("vec%0d", i), tv[i].exp);
        end

        // Vectored interrupt, then same mtvec with an exception cause
        cur = '0; cur.mtvec = 32'h1001; cur.cause = 32'h8000_0007; cur.pc = 32'h300;
        cur.treq = 1'b1;
        drive(cur);
        check_bit("vec_int_ack", TrapAck, 1'b1);
        cur.treq = 1'b0;
        repeat (4) drive(cur);
        drive(cur);
        check_bit("vec_int_redir", Redirect, 1'b1);
        check_word("vec_int_pc", RedirectPC, 32'h101C);
        drive(cur);
        cur.cause = 32'h2; cur.treq = 1'b1;
        drive(cur);
        cur.treq = 1'b0;
        repeat (4) drive(cur);
        drive(cur);
        check_word("vec_exc_pc", RedirectPC, 32'h1000);
        drive(cur);

        // Simultaneous trap and mret with pipeline CSR traffic
        cur = '0; cur.treq = 1'b1; cur.mreq = 1'b1; cur.csren = 1'b1;
        drive(cur);
        check_bit("sim_tack_c0", TrapAck, 1'b1);
        check_bit("sim_mack_c0", MretAck, 1'b0);
        check_bit("sim_grant_c0", CSRGrant, 1'b0);
        cur.treq = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            drive(cur);
            check_bit($sformatf("sim_grant_c%0d", c), CSRGrant, 1'b0);
            check_bit($sformatf("sim_mack_c%0d", c), MretAck, 1'b0);
        end
        drive(cur);
        check_bit("sim_mack_c6", MretAck, 1'b1);
        check_bit("sim_grant_c6", CSRGrant, 1'b0);
        cur.mreq = 1'b0;
        drive(cur);
        check_bit("sim_grant_c7", CSRGrant, 1'b0);
        check_bit("sim_mwe_c7", CsrWriteEn, 1'b1);
        drive(cur);
        check_bit("sim_grant_c8", CSRGrant, 1'b0);
        check_bit("sim_redir_c8", Redirect, 1'b1);
        drive(cur);
        check_bit("sim_grant_c9", CSRGrant, 1'b1);

        // Reset during the mtval write cycle
        cur = '0; cur.treq = 1'b1; cur.pc = 32'h400; cur.val = 32'h55;
        drive(cur);
        cur.treq = 1'b0;
        drive(cur);
        check_bit("rst_mepc_we", CsrWriteEn, 1'b1);
        drive(cur);
        cur.rst = 1'b1;
        drive(cur);
        check_out("rst_c3", '0);
        cur.rst = 1'b0;
        drive(cur);
        check_out("rst_c4", '0);
        drive(cur);
        check_out("rst_c5", '0);
        cur.treq = 1'b1;
        drive(cur);
        check_bit("rst_new_ack", TrapAck, 1'b1);
        cur.treq = 1'b0;
        drive(cur);
        check_out("rst_new_mepc", mk_out(6'b011000, 2'd0, 32'h400, 32'h0));
        repeat (4) drive(cur);
        drive(cur);
        check_out("rst_new_idle", '0);

        // Randomized run against a transaction-level model: each accepted request
        // schedules its list of per-cycle actions.
        q.delete();
        tpend = 1'b0; mpend = 1'b0;
        m_pc = '0; m_cause = '0; m_val = '0;
        for (int c = 0; c < 3000; c++) begin
            ins_t  r;
            outs_t e;
            if (!tpend && $urandom_range(0, 7) == 0) tpend = 1'b1;
            if (!mpend && $urandom_range(0, 9) == 0) mpend = 1'b1;
            r.rst = ($urandom_range(0, 49) == 0);
            r.treq = tpend; r.mreq = mpend; r.csren = ($urandom_range(0, 1) == 1);
            r.cause = $urandom; r.pc = $urandom; r.val = $urandom;
            r.ms = $urandom; r.mtvec = $urandom; r.mepc = $urandom;
            drive(r);
            e = '0;
            if (!r.rst) begin
                if (q.size() == 0) begin
                    e.tack  = r.treq;
                    e.mack  = r.mreq & ~r.treq;
                    e.grant = r.csren & ~r.treq & ~r.mreq;
                    e.stall = r.treq | r.mreq;
                end else begin
                    e.stall = 1'b1;
                    case (q[0])
                        0: begin e.we = 1'b1; e.sel = 2'd0; e.data = m_pc & ~32'h3; end
                        1: begin e.we = 1'b1; e.sel = 2'd1; e.data = m_cause; end
                        2: begin e.we = 1'b1; e.sel = 2'd2; e.data = m_val; end
                        3: begin e.we = 1'b1; e.sel = 2'd3; e.data = trap_mstatus(r.ms); end
                        4: begin e.we = 1'b1; e.sel = 2'd3; e.data = mret_mstatus(r.ms); end
                        5: begin
                            e.redir = 1'b1;
                            e.rpc   = r.mtvec & ~32'h3;
                            if (r.mtvec[1:0] == 2'b01 && m_cause[31])
                                e.rpc = e.rpc + ({1'b0, m_cause[30:0]} << 2);
                        end
                        default: begin e.redir = 1'b1; e.rpc = r.mepc & ~32'h3; end
                    endcase
                end
            end
            check_out($sformatf("rand%0d", c), e);
            if (r.rst) begin
                q.delete();
            end else if (q.size() > 0) begin
                void'(q.pop_front());
            end else if (r.treq) begin
                m_pc = r.pc; m_cause = r.cause; m_val = r.val;
                q = '{0, 1, 2, 3, 5};
                tpend = 1'b0;
            end else if (r.mreq) begin
                q = '{4, 6};
                mpend = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_sequencer.md
# csr_trap_sequencer

Machine-mode trap and `mret` sequencer for the Zicsr CSR register file. It accepts trap and `mret` requests from the pipeline and stalls the pipeline while it works. It drives the CSR file's single internal write port one CSR per cycle (mepc, mcause, mtval, mstatus), then issues a one-cycle PC redirect. It also arbitrates that port against pipeline CSR instructions, so the two never collide.

## Interface
- `XLEN`, default 32: data width of all CSR values and PCs.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `TrapReq`  in  1: level request for a trap; held by the pipeline until `TrapAck`.
- `TrapCause`  in  XLEN: mcause value; bit XLEN-1 = interrupt.
- `TrapPC`  in  XLEN: PC of the trapping instruction.
- `TrapVal`  in  XLEN: mtval value.
- `MretReq`  in  1: level request to execute `mret`; held until `MretAck`.
- `CSREnPipe`  in  1: pipeline CSR instruction wants the CSR file this cycle.
- `MstatusIn`, `MtvecIn`, `MepcIn`  in  XLEN each: current CSR values from the CSR file.
- `CSRGrant`  out  1: pipeline CSR access is permitted this cycle.
- `CsrWriteEn`  out  1: internal write enable into the CSR file.
- `CsrWriteSel`  out  2: internal write target (0 mepc, 1 mcause, 2 mtval, 3 mstatus).
- `CsrWriteData`  out  XLEN: internal write data.
- `Stall`  out  1: freeze the pipeline.
- `TrapAck`, `MretAck`  out  1 each: one-cycle acceptance pulses.
- `Redirect`  out  1: one-cycle PC redirect pulse.
- `RedirectPC`  out  XLEN: redirect target; valid while `Redirect` = 1.

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, M_MSTATUS, REDIRECT.
- IDLE with `TrapReq` = 1:
  - Latch `TrapPC`, `TrapCause` and `TrapVal`.
  - Pulse `TrapAck`; go to T_MEPC.
  - Trap wins over a simultaneous `MretReq`; `MretReq` stays pending and is served after return to IDLE.
- IDLE with `MretReq` = 1 and `TrapReq` = 0: pulse `MretAck`; go to M_MSTATUS.
- Requests are sampled only in IDLE. Requests raised in any other state are ignored until the next IDLE.
- Trap write states (`CsrWriteEn` = 1, one CSR per state):
  - T_MEPC: writes latched PC with bits [1:0] cleared.
  - T_MCAUSE: writes latched cause.
  - T_MTVAL: writes latched val.
  - T_MSTATUS: writes `MstatusIn` with MPIE(7) ← MIE(3), MIE ← 0, MPP[12:11] ← 2'b11.
- M_MSTATUS: writes `MstatusIn` with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- mstatus is always read live from `MstatusIn` in the write cycle, never latched. Bits not named above pass through unchanged.
- REDIRECT: `Redirect` = 1; next state IDLE.
- `RedirectPC` for a trap, with base = {`MtvecIn`[XLEN-1:2], 2'b00}:
  - mtvec mode (`MtvecIn`[1:0]) = 1 and latched interrupt bit = 1: base + (cause[XLEN-2:0] << 2), modulo 2^XLEN.
  - All other cases: base.
- `RedirectPC` for `mret`: {`MepcIn`[XLEN-1:2], 2'b00}. mepc is sampled in the REDIRECT cycle.
- `CSRGrant` = `CSREnPipe` & IDLE & ~`TrapReq` & ~`MretReq`. A pipeline CSR access is never granted in the cycle a trap or `mret` is accepted.
- `Stall` = (state ≠ IDLE) | `TrapReq` | `MretReq`.
- Outputs inactive in a given state are 0: `CsrWriteSel`, `CsrWriteData` and `RedirectPC` are 0 whenever their enable is 0.

## Timing
- Reset:
  - State ← IDLE; latched registers ← 0.
  - All outputs 0 in the cycle after reset and held at 0 while `reset` = 1.
- Reset mid-sequence: next cycle is IDLE. No further CSR writes and no `Redirect` from the aborted sequence. CSR writes already completed before reset are not undone.
- Trap sequence, by cycle:
  - c0: IDLE, accept (`TrapAck`).
  - c1: mepc write.
  - c2: mcause write.
  - c3: mtval write.
  - c4: mstatus write.
  - c5: `Redirect`.
  - c6: IDLE; a new request can be accepted in c6.
- `mret` sequence, by cycle:
  - c0: accept (`MretAck`).
  - c1: mstatus write.
  - c2: `Redirect`.
  - c3: IDLE.
- `Stall` is 1 from c0 through the `Redirect` cycle inclusive. `Stall` is 0 in the first IDLE cycle with no request.
- `CsrWriteEn` is high for exactly 4 cycles per trap and 1 cycle per `mret`.
- The CSR file updates on the edge closing each write cycle, so mstatus changes become visible on `MstatusIn` in the following cycle.

## Test plan
- Direct-mode trap:
  - Stimulus: mtvec = 0x0000_1000, TrapPC = 0x0000_0204, cause = 2, val = 0xDEAD_BEEF, mstatus = 0x0000_0008.
  - Required: writes 0x204, 2, 0xDEADBEEF, 0x0000_1880 on cycles c1–c4.
  - Required: c5 `Redirect` = 1, `RedirectPC` = 0x1000.
- Vectored interrupt:
  - Stimulus: mtvec = 0x0000_1001, cause = 0x8000_0007.
  - Required: `RedirectPC` = 0x101C.
  - Same mtvec with cause = 2 (exception): `RedirectPC` = 0x1000.
- `mret`:
  - Stimulus: mstatus = 0x0000_1880, mepc = 0x0000_0208.
  - Required: c1 writes 0x0000_1888; c2 `RedirectPC` = 0x208; `Stall` low in c3.
- Simultaneous `TrapReq` and `MretReq` in IDLE:
  - Required: trap sequence runs first with `TrapAck` in c0.
  - Required: `MretAck` in c6; no `CSRGrant` anywhere in c0–c8 even with `CSREnPipe` = 1.
- Arbitration:
  - `CSREnPipe` = 1 with no request: `CSRGrant` = 1 and `Stall` = 0.
  - Raise `TrapReq` in the same cycle: `CSRGrant` = 0.
- Reset mid-sequence:
  - Stimulus: assert `reset` during T_MTVAL (c3).
  - Required: mtval is not written, and no mstatus write or `Redirect` follows.
  - Required: all outputs 0 the next cycle; the next `TrapReq` is accepted normally.
